// File: rtl/mem_bus_arbiter.sv
// Two-master arbiter for the shared 8-bit/16-bit memory bus (port 0 = core, port 1 = DMA).
// Define MEM_ARB_RR_EN for a round-robin tie-break out of IDLE; default is fixed priority to port 0.
module mem_bus_arbiter #(
  parameter int MAX_BURST = 8,
  parameter int CNT_W     = 8
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        req0,
  input  logic [15:0] addr0,
  input  logic        we0,
  input  logic [7:0]  wdata0,
  output logic        gnt0,
  input  logic        req1,
  input  logic [15:0] addr1,
  input  logic        we1,
  input  logic [7:0]  wdata1,
  output logic        gnt1,
  output logic [7:0]  rdata,
  output logic [15:0] mem_addr,
  output logic        mem_we,
  output logic [7:0]  mem_wdata,
  input  logic [7:0]  mem_rdata
);

  typedef enum logic [1:0] {IDLE, G0, G1} state_e;

  localparam logic [CNT_W-1:0] BURST_LIM = CNT_W'(MAX_BURST);
  localparam logic [CNT_W-1:0] CNT_ONE   = CNT_W'(1);
  localparam logic [CNT_W-1:0] CNT_SAT   = {CNT_W{1'b1}};

  state_e           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             gnt0_q, gnt1_q;
  logic             tie_to1;

`ifdef MEM_ARB_RR_EN
  // served0_q = 1 when port 0 held the bus most recently; resets to 0 so the first tie goes to port 0.
  logic served0_q, served0_d;

  always_comb begin
    served0_d = served0_q;
    if (state_d == G0)      served0_d = 1'b1;
    else if (state_d == G1) served0_d = 1'b0;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) served0_q <= 1'b0;
    else      served0_q <= served0_d;
  end

  assign tie_to1 = served0_q;
`else
  assign tie_to1 = 1'b0;
`endif

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    unique case (state_q)
      IDLE: begin
        if (req0 && !(req1 && tie_to1)) begin
          state_d = G0;
          cnt_d   = CNT_ONE;
        end else if (req1) begin
          state_d = G1;
          cnt_d   = CNT_ONE;
        end
      end
      G0: begin
        // cnt can exceed the cap while port 1 is quiet, so >= rather than ==
        if (req0 && (!req1 || cnt_q < BURST_LIM)) begin
          cnt_d = (cnt_q == CNT_SAT) ? cnt_q : cnt_q + CNT_ONE;
        end else if (req1) begin
          state_d = G1;
          cnt_d   = CNT_ONE;
        end else begin
          state_d = IDLE;
          cnt_d   = '0;
        end
      end
      G1: begin
        if (req1 && (!req0 || cnt_q < BURST_LIM)) begin
          cnt_d = (cnt_q == CNT_SAT) ? cnt_q : cnt_q + CNT_ONE;
        end else if (req0) begin
          state_d = G0;
          cnt_d   = CNT_ONE;
        end else begin
          state_d = IDLE;
          cnt_d   = '0;
        end
      end
      default: begin
        state_d = IDLE;
        cnt_d   = '0;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      gnt0_q  <= 1'b0;
      gnt1_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      gnt0_q  <= (state_d == G0);
      gnt1_q  <= (state_d == G1);
    end
  end

  // Write enable is qualified by the holder's req so a released grant can never write.
  always_comb begin
    mem_addr  = 16'h0000;
    mem_we    = 1'b0;
    mem_wdata = 8'h00;
    if (gnt0_q) begin
      mem_addr  = addr0;
      mem_we    = we0 & req0;
      mem_wdata = wdata0;
    end else if (gnt1_q) begin
      mem_addr  = addr1;
      mem_we    = we1 & req1;
      mem_wdata = wdata1;
    end
  end

  assign gnt0  = gnt0_q;
  assign gnt1  = gnt1_q;
  assign rdata = mem_rdata;

endmodule
